// File: rtl/decoder_4to16_seq.sv
// decoder_4to16_seq
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// A built-in sweep mode emits every code exactly once, ascending or
// descending, so an encoder/decoder pair can be round-trip checked.
module decoder_4to16_seq #(
    parameter int  IN_W       = 4,
    parameter bit  SWEEP_DESC = 1'b0,
    localparam int OUT_W      = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic [IN_W-1:0]  out_code
);

    // First and terminal sweep codes depend on the sweep direction.
    localparam logic [IN_W-1:0] CNT_FIRST = SWEEP_DESC ? {IN_W{1'b1}} : {IN_W{1'b0}};
    localparam logic [IN_W-1:0] CNT_LAST  = SWEEP_DESC ? {IN_W{1'b0}} : {IN_W{1'b1}};
    localparam logic [IN_W-1:0] CNT_ONE   = {{(IN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [IN_W-1:0]  r_cnt;
    logic             r_sweep_done;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_y;
    logic [IN_W-1:0]  r_out_code;

    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_load_in;
    logic             w_load_sweep;
    logic             w_cnt_last;
    logic [IN_W-1:0]  w_cnt_next;

    // One-hot word with a single bit set at position code.
    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] code);
        onehot = {{(OUT_W-1){1'b0}}, 1'b1} << code;
    endfunction

    // Handshake qualifiers and sweep counter next-value logic.
    always_comb begin
        w_slot_free  = ~r_out_valid | out_ready;
        w_in_ready   = (r_state == ST_IDLE) & ~sweep_start & w_slot_free;
        w_load_in    = in_valid & w_in_ready;
        w_load_sweep = (r_state == ST_SWEEP) & w_slot_free;
        w_cnt_last   = (r_cnt == CNT_LAST);
        w_cnt_next   = SWEEP_DESC ? (r_cnt - CNT_ONE) : (r_cnt + CNT_ONE);
    end

    // Output beat register: load a sweep word or an input word, drain on handshake, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= {OUT_W{1'b0}};
            r_out_code  <= {IN_W{1'b0}};
        end else if (w_load_sweep) begin
            r_out_valid <= 1'b1;
            r_out_y     <= onehot(r_cnt);
            r_out_code  <= r_cnt;
        end else if (w_load_in) begin
            r_out_valid <= 1'b1;
            r_out_y     <= in_en ? onehot(in_code) : {OUT_W{1'b0}};
            r_out_code  <= in_code;
        end else if (r_out_valid & out_ready) begin
            // out_code deliberately keeps the last delivered code
            r_out_valid <= 1'b0;
            r_out_y     <= {OUT_W{1'b0}};
            r_out_code  <= r_out_code;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_y     <= r_out_y;
            r_out_code  <= r_out_code;
        end
    end

    // Sweep sequencer: IDLE -> SWEEP (16 words) -> DRAIN (last handshake) -> IDLE with done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {IN_W{1'b0}};
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sweep_start) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= CNT_FIRST;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    // counter never wraps: the terminal code ends the sweep
                    if (w_slot_free) begin
                        if (w_cnt_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end else begin
                        r_state <= ST_SWEEP;
                    end
                end
                ST_DRAIN: begin
                    if (r_out_valid & out_ready) begin
                        r_state      <= ST_IDLE;
                        r_sweep_done <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {IN_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign sweep_busy = (r_state != ST_IDLE);
    assign sweep_done = r_sweep_done;
    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;
    assign out_code   = r_out_code;

endmodule

// File: tb/tb_decoder_4to16_seq.sv
// Scoreboard bench for decoder_4to16_seq: one ascending-sweep instance and
// one descending-sweep instance, directed vectors, queue-based checking.
`timescale 1ns/1ps
module tb_decoder_4to16_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ascending instance
    logic        a_in_valid, a_in_ready, a_in_en, a_sweep_start, a_sweep_busy, a_sweep_done;
    logic        a_out_valid, a_out_ready;
    logic [3:0]  a_in_code, a_out_code;
    logic [15:0] a_out_y;
    // descending instance
    logic        d_in_valid, d_in_ready, d_in_en, d_sweep_start, d_sweep_busy, d_sweep_done;
    logic        d_out_valid, d_out_ready;
    logic [3:0]  d_in_code, d_out_code;
    logic [15:0] d_out_y;

    decoder_4to16_seq #(.IN_W(4), .SWEEP_DESC(1'b0)) u_dut_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code), .in_en(a_in_en),
        .sweep_start(a_sweep_start), .sweep_busy(a_sweep_busy), .sweep_done(a_sweep_done),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y), .out_code(a_out_code)
    );

    decoder_4to16_seq #(.IN_W(4), .SWEEP_DESC(1'b1)) u_dut_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_code(d_in_code), .in_en(d_in_en),
        .sweep_start(d_sweep_start), .sweep_busy(d_sweep_busy), .sweep_done(d_sweep_done),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_y(d_out_y), .out_code(d_out_code)
    );

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  code;
    } beat_t;

    beat_t q_a[$];
    beat_t q_d[$];
    int n_checks = 0;
    int n_fail   = 0;
    int a_beats  = 0;
    int d_beats  = 0;
    int a_done_cnt = 0;
    int d_done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference 16-to-4 encoder
    function automatic logic [3:0] enc16(input logic [15:0] y);
        enc16 = 4'd0;
        for (int i = 0; i < 16; i++) if (y[i]) enc16 = i[3:0];
    endfunction

    function automatic beat_t mk(input logic [15:0] y, input logic [3:0] code);
        beat_t b;
        b.y = y;
        b.code = code;
        return b;
    endfunction

    // monitor + input recorder: pop/compare on output handshake, push on input accept
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            a_beats++;
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL asc_unexpected_beat: got y=%h code=%0d, expected no beat", a_out_y, a_out_code);
            end else begin
                e = q_a.pop_front();
                n_checks--;
                chk("asc_beat_y", a_out_y, e.y);
                chk("asc_beat_code", a_out_code, e.code);
            end
            if (a_out_y != 16'h0) chk("asc_enc_roundtrip", enc16(a_out_y), a_out_code);
        end
        if (rst_n && a_in_valid && a_in_ready)
            q_a.push_back(mk(a_in_en ? (16'h1 << a_in_code) : 16'h0, a_in_code));
        if (rst_n && a_sweep_done) a_done_cnt++;

        if (rst_n && d_out_valid && d_out_ready) begin
            d_beats++;
            n_checks++;
            if (q_d.size() == 0) begin
                n_fail++;
                $display("FAIL desc_unexpected_beat: got y=%h code=%0d, expected no beat", d_out_y, d_out_code);
            end else begin
                e = q_d.pop_front();
                n_checks--;
                chk("desc_beat_y", d_out_y, e.y);
                chk("desc_beat_code", d_out_code, e.code);
            end
        end
        if (rst_n && d_in_valid && d_in_ready)
            q_d.push_back(mk(d_in_en ? (16'h1 << d_in_code) : 16'h0, d_in_code));
        if (rst_n && d_sweep_done) d_done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int base_done;
        int bad;
        bit seen;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_code = 4'd0; a_in_en = 1'b0; a_sweep_start = 1'b0; a_out_ready = 1'b0;
        d_in_valid = 1'b0; d_in_code = 4'd0; d_in_en = 1'b0; d_sweep_start = 1'b0; d_out_ready = 1'b0;

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_out_valid", a_out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_y", a_out_y, 16'h0000);
        chk("rst_out_code", a_out_code, 4'd0);
        chk("rst_busy", a_sweep_busy, 1'b0);
        chk("rst_done", a_sweep_done, 1'b0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_desc_in_ready", d_in_ready, 1'b1);

        // 2. single decode and backpressure
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_code = 4'd5; a_in_en = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        @(negedge clk);
        chk("dec5_valid", a_out_valid, 1'b1);
        chk("dec5_y", a_out_y, 16'h0020);
        chk("dec5_code", a_out_code, 4'd5);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_y", a_out_y, 16'h0020);
            chk("stall_in_ready", a_in_ready, 1'b0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_valid", a_out_valid, 1'b0);
        chk("drain_y", a_out_y, 16'h0000);
        chk("drain_code_held", a_out_code, 4'd5);

        // 3. full-rate codes 0..15, then enable low
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1; a_in_code = i[3:0]; a_in_en = 1'b1;
            if (i > 0) begin
                @(negedge clk);
                chk("full_rate_valid", a_out_valid, 1'b1);
                chk("full_rate_y", a_out_y, 32'h1 << (i - 1));
            end
        end
        @(posedge clk); #1;
        a_in_code = 4'd9; a_in_en = 1'b0;
        @(negedge clk);
        chk("full_rate_last_y", a_out_y, 16'h8000);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_en = 1'b1;
        @(negedge clk);
        chk("en0_valid", a_out_valid, 1'b1);
        chk("en0_y", a_out_y, 16'h0000);
        chk("en0_code", a_out_code, 4'd9);
        @(posedge clk); #1;

        // 4. ascending sweep at full rate
        a_sweep_start = 1'b1;
        for (int k = 0; k < 16; k++) q_a.push_back(mk(16'h1 << k, k[3:0]));
        base = a_beats;
        base_done = a_done_cnt;
        @(posedge clk); #1;
        a_sweep_start = 1'b0;
        @(negedge clk);
        chk("asc_busy_start", a_sweep_busy, 1'b1);
        chk("asc_in_ready_busy", a_in_ready, 1'b0);
        cyc = 1;
        while (!a_sweep_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("asc_done_cycle", cyc, 18);
        chk("asc_sweep_beats", a_beats - base, 16);
        @(negedge clk);
        chk("asc_busy_after", a_sweep_busy, 1'b0);
        chk("asc_done_single", a_sweep_done, 1'b0);
        chk("asc_done_count", a_done_cnt - base_done, 1);

        // 5. descending sweep, random out_ready, in_valid held high
        @(posedge clk); #1;
        d_in_valid = 1'b1; d_in_code = 4'd2; d_in_en = 1'b1; d_sweep_start = 1'b1; d_out_ready = 1'b1;
        for (int k = 15; k >= 0; k--) q_d.push_back(mk(16'h1 << k, k[3:0]));
        base = d_beats;
        base_done = d_done_cnt;
        @(negedge clk);
        chk("desc_in_ready_start", d_in_ready, 1'b0);
        @(posedge clk); #1;
        d_sweep_start = 1'b0;
        cyc = 0; bad = 0; seen = 1'b0;
        while (!seen && cyc < 300) begin
            d_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (d_sweep_busy && d_in_ready) bad++;
            if (d_sweep_done) seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("desc_done_seen", seen, 1'b1);
        chk("desc_in_ready_while_busy", bad, 0);
        chk("desc_sweep_beats", d_beats - base, 16);
        d_in_valid = 1'b0; d_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("desc_done_count", d_done_cnt - base_done, 1);
        chk("desc_queue_empty", q_d.size(), 0);

        // 6. collision, then reset after the 7th sweep beat
        a_sweep_start = 1'b1; a_in_valid = 1'b1; a_in_code = 4'd3; a_in_en = 1'b1; a_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) q_a.push_back(mk(16'h1 << k, k[3:0]));
        base = a_beats;
        base_done = a_done_cnt;
        @(negedge clk);
        chk("collide_in_ready", a_in_ready, 1'b0);
        @(posedge clk); #1;
        a_sweep_start = 1'b0; a_in_valid = 1'b0;
        cyc = 0;
        while (a_beats < base + 7 && cyc < 60) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("abort_beats_before", a_beats - base, 7);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", a_out_valid, 1'b0);
        chk("abort_out_y", a_out_y, 16'h0000);
        chk("abort_out_code", a_out_code, 4'd0);
        chk("abort_busy", a_sweep_busy, 1'b0);
        chk("abort_done", a_sweep_done, 1'b0);
        q_a.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_busy", a_sweep_busy, 1'b0);
        chk("abort_idle_in_ready", a_in_ready, 1'b1);
        chk("abort_no_done", a_done_cnt - base_done, 0);
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_code = 4'd12; a_in_en = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_y", a_out_y, 16'h1000);
        chk("post_reset_code", a_out_code, 4'd12);
        repeat (3) @(posedge clk);
        #1;
        chk("asc_queue_empty", q_a.size(), 0);
        chk("abort_no_late_done", a_done_cnt - base_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
